// File: rtl/ct_l2c_spsram_arb_pkg.sv
// Shared widths, FSM encoding and byte-enable expansion for the L2 data SRAM arbiter.
package ct_l2c_spsram_arb_pkg;

    localparam int SPS_ADDR_W = 13;
    localparam int SPS_DATA_W = 128;
    localparam int SPS_BE_W   = 16;
    localparam int SPS_BYTE_W = SPS_DATA_W / SPS_BE_W;

    // state | meaning
    // INIT  | zero-filling the macro, one entry per cycle, requesters stalled
    // RUN   | normal operation, one round-robin grant per cycle
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Active-high byte enables -> active-low per-bit macro write enables.
    function automatic logic [SPS_DATA_W-1:0] be_to_wen(input logic [SPS_BE_W-1:0] be);
        logic [SPS_DATA_W-1:0] wen;
        for (int i = 0; i < SPS_DATA_W; i++) begin
            wen[i] = ~be[i / SPS_BYTE_W];
        end
        return wen;
    endfunction

endpackage

// File: rtl/ct_l2c_spsram_rr_arb2.sv
// Two-way round-robin grant; the pointer always moves to the side that was not just served.
module ct_l2c_spsram_rr_arb2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic vld0_i,
    input  logic vld1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // ptr_q = 0 -> side 0 preferred on a tie
    logic ptr_q;
    logic ptr_d;

    assign gnt0_o = en_i & vld0_i & (~vld1_i | ~ptr_q);
    assign gnt1_o = en_i & vld1_i & (~vld0_i |  ptr_q);

    // Point away from whichever side was granted this cycle.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt0_o) begin
            ptr_d = 1'b1;
        end else if (gnt1_o) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ct_l2c_spsram_arb.sv
// Sequencer/arbiter in front of one single-port data SRAM macro: zero-fill after
// reset, round-robin sharing between the refill (r0) and lookup (r1) paths,
// registered macro inputs and a 3-cycle tagged read return.
module ct_l2c_spsram_arb
    import ct_l2c_spsram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = SPS_ADDR_W,
    parameter int DATA_WIDTH = SPS_DATA_W,
    parameter int BE_WIDTH   = SPS_BE_W,
    parameter int INIT_EN    = 1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  r0_req_vld,
    input  logic                  r0_req_wr,
    input  logic [ADDR_WIDTH-1:0] r0_req_addr,
    input  logic [DATA_WIDTH-1:0] r0_req_wdata,
    input  logic [BE_WIDTH-1:0]   r0_req_be,
    output logic                  r0_req_rdy,
    input  logic                  r1_req_vld,
    input  logic                  r1_req_wr,
    input  logic [ADDR_WIDTH-1:0] r1_req_addr,
    input  logic [DATA_WIDTH-1:0] r1_req_wdata,
    input  logic [BE_WIDTH-1:0]   r1_req_be,
    output logic                  r1_req_rdy,
    output logic                  rsp_vld,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    output logic [DATA_WIDTH-1:0] sram_wen,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [0:0] ST_RESET   = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic       DONE_RESET = (INIT_EN == 0);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  cen_q, cen_d;
    logic                  gwen_q, gwen_d;
    logic [DATA_WIDTH-1:0] wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    // s1: read on the macro pins, s2: read data on sram_q
    logic                  s1_vld_q, s1_vld_d, s1_id_q, s1_id_d;
    logic                  s2_vld_q, s2_id_q;
    logic                  rsp_vld_q, rsp_id_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    logic                  run;
    logic                  gnt0, gnt1;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_WIDTH-1:0]   sel_be;

    assign run = (state_q == ST_RUN);

    ct_l2c_spsram_rr_arb2 u_rr_arb (
        .clk_i  (forever_cpuclk),
        .rst_i  (cpurst),
        .en_i   (run),
        .vld0_i (r0_req_vld),
        .vld1_i (r1_req_vld),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    assign r0_req_rdy = gnt0;
    assign r1_req_rdy = gnt1;

    assign sel_wr    = gnt1 ? r1_req_wr    : r0_req_wr;
    assign sel_addr  = gnt1 ? r1_req_addr  : r0_req_addr;
    assign sel_wdata = gnt1 ? r1_req_wdata : r0_req_wdata;
    assign sel_be    = gnt1 ? r1_req_be    : r0_req_be;

    // Next macro command: zero-fill write in INIT, granted request in RUN, idle otherwise.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        cen_d    = 1'b1;
        gwen_d   = 1'b1;
        wen_d    = '1;
        a_d      = a_q;
        d_d      = d_q;
        s1_vld_d = 1'b0;
        s1_id_d  = s1_id_q;
        case (state_q)
            ST_INIT: begin
                cen_d  = 1'b0;
                gwen_d = 1'b0;
                wen_d  = '0;
                a_d    = cnt_q;
                d_d    = '0;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                if (gnt0 | gnt1) begin
                    cen_d    = 1'b0;
                    gwen_d   = ~sel_wr;
                    a_d      = sel_addr;
                    s1_vld_d = ~sel_wr;
                    s1_id_d  = gnt1;
                    if (sel_wr) begin
                        wen_d = be_to_wen(sel_be);
                        d_d   = sel_wdata;
                    end
                end
            end
        endcase
    end

    // FSM, init counter and registered macro inputs.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            done_q  <= DONE_RESET;
            cen_q   <= 1'b1;
            gwen_q  <= 1'b1;
            wen_q   <= '1;
            a_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            cen_q   <= cen_d;
            gwen_q  <= gwen_d;
            wen_q   <= wen_d;
            a_q     <= a_d;
            d_q     <= d_d;
        end
    end

    // Read tag pipeline and registered response; reset drops anything in flight.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            s1_vld_q   <= 1'b0;
            s1_id_q    <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_id_q    <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_id_q   <= s1_id_d;
            s2_vld_q  <= s1_vld_q;
            s2_id_q   <= s1_id_q;
            rsp_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                rsp_id_q   <= s2_id_q;
                rsp_data_q <= sram_q;
            end
        end
    end

    assign sram_cen  = cen_q;
    assign sram_gwen = gwen_q;
    assign sram_wen  = wen_q;
    assign sram_a    = a_q;
    assign sram_d    = d_q;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_ct_l2c_spsram_arb.sv
// Bench for ct_l2c_spsram_arb: behavioural macro, reference memory + grant model.
module tb_ct_l2c_spsram_arb;

    localparam int DEPTH = 8192;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         r0_req_vld = 0, r0_req_wr = 0, r1_req_vld = 0, r1_req_wr = 0;
    logic [12:0]  r0_req_addr = 0, r1_req_addr = 0;
    logic [127:0] r0_req_wdata = 0, r1_req_wdata = 0;
    logic [15:0]  r0_req_be = 0, r1_req_be = 0;
    logic         r0_req_rdy, r1_req_rdy;
    logic         rsp_vld, rsp_id, init_done;
    logic [127:0] rsp_data;
    logic         sram_cen, sram_gwen;
    logic [12:0]  sram_a;
    logic [127:0] sram_d, sram_wen;
    logic [127:0] sram_q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cnt;

    always #5 clk = ~clk;

    ct_l2c_spsram_arb dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .r0_req_vld     (r0_req_vld),
        .r0_req_wr      (r0_req_wr),
        .r0_req_addr    (r0_req_addr),
        .r0_req_wdata   (r0_req_wdata),
        .r0_req_be      (r0_req_be),
        .r0_req_rdy     (r0_req_rdy),
        .r1_req_vld     (r1_req_vld),
        .r1_req_wr      (r1_req_wr),
        .r1_req_addr    (r1_req_addr),
        .r1_req_wdata   (r1_req_wdata),
        .r1_req_be      (r1_req_be),
        .r1_req_rdy     (r1_req_rdy),
        .rsp_vld        (rsp_vld),
        .rsp_id         (rsp_id),
        .rsp_data       (rsp_data),
        .init_done      (init_done),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_a         (sram_a),
        .sram_d         (sram_d),
        .sram_wen       (sram_wen),
        .sram_q         (sram_q)
    );

    // Behavioural macro: starts full of garbage, 1-cycle read, per-bit active-low write.
    logic [127:0] mem [DEPTH];
    bit seeded = 0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= {$urandom, $urandom, $urandom, $urandom};
            seeded <= 1;
        end else if (sram_cen == 1'b0) begin
            if (sram_gwen == 1'b0) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else                   sram_q <= mem[sram_a];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst) begin
        if (rst) rel_cnt <= 0;
        else     rel_cnt <= rel_cnt + 1;
    end

    // Reference model: zero-filled array after DEPTH cycles, RR preference, reads due 3 cycles after accept.
    typedef struct { int cyc; logic id; logic [127:0] data; } rsp_t;
    rsp_t         exp_q[$];
    rsp_t         obs_q[$];
    int           gnt_log[$];
    logic [3:0]   rdy_log[$];
    logic [127:0] ref_mem [DEPTH];
    logic         pref;
    logic         m_run, m_g0, m_g1;

    assign m_run = (rel_cnt >= DEPTH);
    assign m_g0  = m_run && r0_req_vld && (!r1_req_vld || pref == 1'b0);
    assign m_g1  = m_run && r1_req_vld && (!r0_req_vld || pref == 1'b1);

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d, input logic [15:0] be);
        logic [127:0] r = old;
        for (int b = 0; b < 16; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pref <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] <= '0;
            exp_q.delete();
        end else begin
            rdy_log.push_back({m_g0, m_g1, r0_req_rdy, r1_req_rdy});
            if (r0_req_vld && r0_req_rdy) gnt_log.push_back(0);
            if (r1_req_vld && r1_req_rdy) gnt_log.push_back(1);
            if (m_g0) begin
                if (r0_req_wr) ref_mem[r0_req_addr] <= merge(ref_mem[r0_req_addr], r0_req_wdata, r0_req_be);
                else exp_q.push_back('{cyc + 3, 1'b0, ref_mem[r0_req_addr]});
                pref <= 1'b1;
            end else if (m_g1) begin
                if (r1_req_wr) ref_mem[r1_req_addr] <= merge(ref_mem[r1_req_addr], r1_req_wdata, r1_req_be);
                else exp_q.push_back('{cyc + 3, 1'b1, ref_mem[r1_req_addr]});
                pref <= 1'b0;
            end
            if (rsp_vld) obs_q.push_back('{cyc, rsp_id, rsp_data});
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic w, input logic [12:0] a, input logic [127:0] d, input logic [15:0] be);
        r0_req_vld = v; r0_req_wr = w; r0_req_addr = a; r0_req_wdata = d; r0_req_be = be;
    endtask

    task automatic drive1(input logic v, input logic w, input logic [12:0] a, input logic [127:0] d, input logic [15:0] be);
        r1_req_vld = v; r1_req_wr = w; r1_req_addr = a; r1_req_wdata = d; r1_req_be = be;
    endtask

    task automatic idle();
        r0_req_vld = 0;
        r1_req_vld = 0;
    endtask

    // Zero-fill sequence after a reset release; caller releases reset at posedge+#1.
    task automatic run_init_check(input string tag);
        int nwr = 0, bad_ord = 0, first_bad = -1, bad_rdy = 0, done_nwr = -1;
        drive0(1, 0, 13'd5, '0, '0);
        for (int k = 0; k < 8400 && done_nwr < 0; k++) begin
            @(negedge clk);
            if (sram_cen == 1'b0) begin
                if (sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0 ||
                    sram_a !== 13'(nwr) || rel_cnt != nwr + 1) begin
                    if (bad_ord == 0) first_bad = nwr;
                    bad_ord++;
                end
                nwr++;
            end
            if (init_done !== 1'b1 && r0_req_rdy !== 1'b0) bad_rdy++;
            if (init_done === 1'b1) done_nwr = nwr;
            next_cyc();
            if (nwr >= 8000) r0_req_vld = 0;
        end
        checks++;
        if (done_nwr != DEPTH) begin
            errors++;
            $display("FAIL %s_done_at_write act=%0d exp=%0d", tag, done_nwr, DEPTH);
        end
        checks++;
        if (bad_ord != 0) begin
            errors++;
            $display("FAIL %s_fill_order bad=%0d first_entry=%0d exp=0_bad", tag, bad_ord, first_bad);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL %s_rdy_during_init act=%0d exp=0", tag, bad_rdy);
        end
        @(negedge clk);
        checks++;
        if (sram_cen !== 1'b1 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_after_fill cen=%b done=%b exp cen=1 done=1", tag, sram_cen, init_done);
        end
        next_cyc();
    endtask

    task automatic test_reset();
        drive0(1, 0, 13'd1, '0, '0);
        drive1(1, 0, 13'd2, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sram_cen !== 1'b1)   begin errors++; $display("FAIL rst_cen act=%b exp=1", sram_cen); end
        checks++; if (sram_gwen !== 1'b1)  begin errors++; $display("FAIL rst_gwen act=%b exp=1", sram_gwen); end
        checks++; if (sram_wen !== '1)     begin errors++; $display("FAIL rst_wen act=%h exp=all1", sram_wen); end
        checks++; if (sram_a !== 13'd0)    begin errors++; $display("FAIL rst_a act=%h exp=0", sram_a); end
        checks++; if (sram_d !== '0)       begin errors++; $display("FAIL rst_d act=%h exp=0", sram_d); end
        checks++; if (rsp_vld !== 1'b0)    begin errors++; $display("FAIL rst_rsp_vld act=%b exp=0", rsp_vld); end
        checks++; if (rsp_id !== 1'b0)     begin errors++; $display("FAIL rst_rsp_id act=%b exp=0", rsp_id); end
        checks++; if (rsp_data !== '0)     begin errors++; $display("FAIL rst_rsp_data act=%h exp=0", rsp_data); end
        checks++; if (init_done !== 1'b0)  begin errors++; $display("FAIL rst_init_done act=%b exp=0", init_done); end
        checks++; if (r0_req_rdy !== 1'b0 || r1_req_rdy !== 1'b0) begin
            errors++; $display("FAIL rst_rdy act=%b%b exp=00", r0_req_rdy, r1_req_rdy);
        end
        r1_req_vld = 0;
        next_cyc();
        rst = 0;
        run_init_check("init");
    endtask

    task automatic test_write_read();
        int t;
        logic [127:0] exp_d = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [127:0] exp_wen = {{64{1'b1}}, {64{1'b0}}};
        obs_q.delete();
        t = cyc;
        drive0(1, 1, 13'h0A5, '1, 16'h00FF);
        @(negedge clk);
        checks++; if (r0_req_rdy !== 1'b1) begin errors++; $display("FAIL wr_rdy act=%b exp=1", r0_req_rdy); end
        next_cyc();
        r0_req_vld = 0;
        drive1(1, 0, 13'h0A5, '0, '0);
        @(negedge clk);
        checks++; if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== 13'h0A5) begin
            errors++; $display("FAIL wr_pins cen=%b gwen=%b a=%h exp 0 0 0a5", sram_cen, sram_gwen, sram_a);
        end
        checks++; if (sram_wen !== exp_wen) begin errors++; $display("FAIL wr_wen act=%h exp=%h", sram_wen, exp_wen); end
        checks++; if (r1_req_rdy !== 1'b1) begin errors++; $display("FAIL rd_rdy act=%b exp=1", r1_req_rdy); end
        next_cyc();
        idle();
        repeat (6) next_cyc();
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL raw_rsp_count act=%0d exp=1", obs_q.size());
        end else begin
            checks++; if (obs_q[0].id !== 1'b1)   begin errors++; $display("FAIL raw_rsp_id act=%b exp=1", obs_q[0].id); end
            checks++; if (obs_q[0].data !== exp_d) begin errors++; $display("FAIL raw_rsp_data act=%h exp=%h", obs_q[0].data, exp_d); end
            checks++; if (obs_q[0].cyc != t + 4)   begin errors++; $display("FAIL raw_rsp_cycle act=%0d exp=%0d", obs_q[0].cyc, t + 4); end
        end
    endtask

    task automatic test_alternate();
        int bad = 0;
        gnt_log.delete(); obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive0(1, 0, (i == 0) ? 13'h0A5 : 13'($urandom_range(0, 255)), '0, '0);
            drive1(1, 0, 13'($urandom_range(0, 255)), '0, '0);
            next_cyc();
        end
        idle();
        repeat (6) next_cyc();
        for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] != i % 2) bad++;
        checks++;
        if (gnt_log.size() != 6 || bad != 0) begin
            errors++; $display("FAIL alt_grants count=%0d bad=%0d exp count=6 order=010101", gnt_log.size(), bad);
        end
        bad = 0;
        if (obs_q.size() == 6 && exp_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                if (obs_q[i].id !== 1'(i % 2) || obs_q[i].cyc != obs_q[0].cyc + i ||
                    obs_q[i].data !== exp_q[i].data || obs_q[i].cyc != exp_q[i].cyc) bad++;
            end
        end else bad = 99;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL alt_rsp obs=%0d exp=%0d bad=%0d", obs_q.size(), exp_q.size(), bad);
        end
    endtask

    task automatic test_single_then_both();
        int bad = 0;
        gnt_log.delete();
        r0_req_vld = 0;
        for (int i = 0; i < 4; i++) begin
            drive1(1, 0, 13'(i), '0, '0);
            next_cyc();
        end
        drive0(1, 0, 13'd7, '0, '0);
        drive1(1, 0, 13'd8, '0, '0);
        @(negedge clk);
        checks++;
        if (r0_req_rdy !== 1'b1 || r1_req_rdy !== 1'b0) begin
            errors++; $display("FAIL tie_after_r1 rdy=%b%b exp=10", r0_req_rdy, r1_req_rdy);
        end
        next_cyc();
        idle();
        repeat (5) next_cyc();
        for (int i = 0; i < gnt_log.size(); i++) if (gnt_log[i] != ((i < 4) ? 1 : 0)) bad++;
        checks++;
        if (gnt_log.size() != 5 || bad != 0) begin
            errors++; $display("FAIL single_grants count=%0d bad=%0d exp count=5 order=11110", gnt_log.size(), bad);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        rdy_log.delete(); obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            drive0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? 13'd8191 : 13'($urandom_range(0, 7)),
                   {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
            drive1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? 13'd8191 : 13'($urandom_range(0, 7)),
                   {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
            next_cyc();
        end
        idle();
        repeat (6) next_cyc();
        foreach (rdy_log[i]) if (rdy_log[i][3:2] !== rdy_log[i][1:0]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rand_rdy bad_cycles=%0d exp=0", bad); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_rsp_count act=%0d exp=%0d", obs_q.size(), exp_q.size());
        end else begin
            bad = 0;
            foreach (obs_q[i]) if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].id !== exp_q[i].id || obs_q[i].data !== exp_q[i].data) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rand_rsp_content bad=%0d exp=0", bad); end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        obs_q.delete();
        drive0(1, 0, 13'd1, '0, '0);
        next_cyc();
        r0_req_vld = 0;
        drive1(1, 0, 13'd2, '0, '0);
        next_cyc();
        idle();
        rst = 1;
        #1;
        checks++;
        if (sram_cen !== 1'b1 || rsp_vld !== 1'b0 || init_done !== 1'b0) begin
            errors++; $display("FAIL mid_rst_async cen=%b rsp_vld=%b done=%b exp 1 0 0", sram_cen, rsp_vld, init_done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (sram_cen !== 1'b1 || rsp_vld !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_rst_hold bad=%0d exp=0", bad); end
        next_cyc();
        rst = 0;
        run_init_check("reinit");
        repeat (5) next_cyc();
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL no_stale_rsp act=%0d exp=0", obs_q.size()); end
    endtask

    task automatic test_wrap();
        int t;
        logic [127:0] wd = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        obs_q.delete();
        t = cyc;
        drive0(1, 1, 13'd8191, wd, 16'hFFFF);
        next_cyc();
        drive0(1, 0, 13'd8191, '0, '0);
        next_cyc();
        drive0(1, 0, 13'd0, '0, '0);
        next_cyc();
        idle();
        repeat (6) next_cyc();
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL wrap_rsp_count act=%0d exp=2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].data !== wd || obs_q[0].id !== 1'b0 || obs_q[0].cyc != t + 4) begin
                errors++; $display("FAIL wrap_top data=%h id=%b cyc=%0d exp data=%h id=0 cyc=%0d", obs_q[0].data, obs_q[0].id, obs_q[0].cyc, wd, t + 4);
            end
            checks++;
            if (obs_q[1].data !== '0 || obs_q[1].cyc != t + 5) begin
                errors++; $display("FAIL wrap_zero data=%h cyc=%0d exp data=0 cyc=%0d", obs_q[1].data, obs_q[1].cyc, t + 5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_single_then_both();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
